// File: rtl/geri_yazma_hakemi.sv
// Write-back arbiter and register scoreboard in front of the 32x32 register file.
// Optional macro GERI_YAZMA_ILERI_YONLENDIRME_EN adds write-port forwarding to decode.
module geri_yazma_hakemi #(
  parameter int ISTEKCI_SAYISI = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ISTEKCI_SAYISI-1:0]      istek_gecerli_i,
  input  logic [5*ISTEKCI_SAYISI-1:0]    istek_adres_i,
  input  logic [32*ISTEKCI_SAYISI-1:0]   istek_deger_i,
  output logic [ISTEKCI_SAYISI-1:0]      istek_hazir_o,
  output logic                           yaz_o,
  output logic [4:0]                     hy_adres_o,
  output logic [31:0]                    hy_deger_o,
  input  logic                           rezerve_i,
  input  logic [4:0]                     rezerve_adres_i,
  input  logic [4:0]                     ky1_adres_i,
  input  logic [4:0]                     ky2_adres_i,
  output logic                           ky1_mesgul_o,
  output logic                           ky2_mesgul_o,
  output logic                           ky1_ileri_o,
  output logic                           ky2_ileri_o,
  output logic [31:0]                    ileri_deger_o
);

  localparam int PW = (ISTEKCI_SAYISI > 1) ? $clog2(ISTEKCI_SAYISI) : 1;

  logic [PW-1:0]             r_oncelik;
  logic                      r_yaz;
  logic [4:0]                r_hy_adres;
  logic [31:0]               r_hy_deger;
  logic [31:0]               r_mesgul;

  logic [ISTEKCI_SAYISI-1:0] w_hazir;
  logic                      w_aktarim;
  logic [PW-1:0]             w_secilen;
  logic [PW-1:0]             w_sonraki_oncelik;
  logic [4:0]                w_sec_adres;
  logic [31:0]               w_sec_deger;
  logic [31:0]               w_set;
  logic [31:0]               w_clr;
  logic                      w_ky1_mesgul_ham;
  logic                      w_ky2_mesgul_ham;

  // Scan from the priority pointer upward with wrap; the first valid requester wins.
  always_comb begin
    w_hazir   = '0;
    w_aktarim = 1'b0;
    w_secilen = '0;
    for (int i = 0; i < ISTEKCI_SAYISI; i++) begin
      int idx;
      idx = (int'(r_oncelik) + i) % ISTEKCI_SAYISI;
      if (!w_aktarim && istek_gecerli_i[idx]) begin
        w_aktarim    = 1'b1;
        w_secilen    = PW'(idx);
        w_hazir[idx] = 1'b1;
      end
    end
  end

  // Grant is masked during reset so no requester sees a phantom acceptance.
  assign istek_hazir_o = rst_ni ? w_hazir : '0;

  assign w_sec_adres = istek_adres_i[5*int'(w_secilen) +: 5];
  assign w_sec_deger = istek_deger_i[32*int'(w_secilen) +: 32];

  assign w_sonraki_oncelik = (w_secilen == PW'(ISTEKCI_SAYISI - 1)) ? '0
                                                                    : w_secilen + PW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_oncelik  <= '0;
      r_yaz      <= 1'b0;
      r_hy_adres <= '0;
      r_hy_deger <= '0;
    end else begin
      r_yaz <= w_aktarim && (w_sec_adres != 5'd0);
      if (w_aktarim) begin
        r_oncelik  <= w_sonraki_oncelik;
        r_hy_adres <= w_sec_adres;
        r_hy_deger <= w_sec_deger;
      end
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rezerve_i && (rezerve_adres_i != 5'd0)) w_set[rezerve_adres_i] = 1'b1;
    if (r_yaz) w_clr[r_hy_adres] = 1'b1;
  end

  // Clear and set land on the same edge as the register-file write; set wins a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mesgul <= '0;
    end else begin
      r_mesgul <= ((r_mesgul & ~w_clr) | w_set) & ~32'h1;
    end
  end

  assign yaz_o      = r_yaz;
  assign hy_adres_o = r_hy_adres;
  assign hy_deger_o = r_hy_deger;

  assign w_ky1_mesgul_ham = (ky1_adres_i != 5'd0) && r_mesgul[ky1_adres_i];
  assign w_ky2_mesgul_ham = (ky2_adres_i != 5'd0) && r_mesgul[ky2_adres_i];

`ifdef GERI_YAZMA_ILERI_YONLENDIRME_EN
  assign ky1_ileri_o   = r_yaz && (r_hy_adres == ky1_adres_i) && (ky1_adres_i != 5'd0);
  assign ky2_ileri_o   = r_yaz && (r_hy_adres == ky2_adres_i) && (ky2_adres_i != 5'd0);
  assign ileri_deger_o = r_hy_deger;
  assign ky1_mesgul_o  = w_ky1_mesgul_ham && !ky1_ileri_o;
  assign ky2_mesgul_o  = w_ky2_mesgul_ham && !ky2_ileri_o;
`else
  assign ky1_ileri_o   = 1'b0;
  assign ky2_ileri_o   = 1'b0;
  assign ileri_deger_o = '0;
  assign ky1_mesgul_o  = w_ky1_mesgul_ham;
  assign ky2_mesgul_o  = w_ky2_mesgul_ham;
`endif

endmodule

// File: tb/tb_geri_yazma_hakemi.sv
// Directed bench for geri_yazma_hakemi: arbitration, write port, scoreboard, reset.
module tb_geri_yazma_hakemi;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [2:0]  istek_gecerli_i;
  logic [14:0] istek_adres_i;
  logic [95:0] istek_deger_i;
  logic [2:0]  istek_hazir_o;
  logic        yaz_o;
  logic [4:0]  hy_adres_o;
  logic [31:0] hy_deger_o;
  logic        rezerve_i;
  logic [4:0]  rezerve_adres_i;
  logic [4:0]  ky1_adres_i;
  logic [4:0]  ky2_adres_i;
  logic        ky1_mesgul_o;
  logic        ky2_mesgul_o;
  logic        ky1_ileri_o;
  logic        ky2_ileri_o;
  logic [31:0] ileri_deger_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  geri_yazma_hakemi #(.ISTEKCI_SAYISI(3)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .istek_gecerli_i (istek_gecerli_i),
    .istek_adres_i   (istek_adres_i),
    .istek_deger_i   (istek_deger_i),
    .istek_hazir_o   (istek_hazir_o),
    .yaz_o           (yaz_o),
    .hy_adres_o      (hy_adres_o),
    .hy_deger_o      (hy_deger_o),
    .rezerve_i       (rezerve_i),
    .rezerve_adres_i (rezerve_adres_i),
    .ky1_adres_i     (ky1_adres_i),
    .ky2_adres_i     (ky2_adres_i),
    .ky1_mesgul_o    (ky1_mesgul_o),
    .ky2_mesgul_o    (ky2_mesgul_o),
    .ky1_ileri_o     (ky1_ileri_o),
    .ky2_ileri_o     (ky2_ileri_o),
    .ileri_deger_o   (ileri_deger_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
    istek_adres_i[5*k +: 5]  = a;
    istek_deger_i[32*k +: 32] = d;
  endtask

  task automatic reserve(input logic [4:0] a);
    rezerve_i       = 1'b1;
    rezerve_adres_i = a;
    tick();
    rezerve_i       = 1'b0;
    rezerve_adres_i = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rr_tab [6];
    int          rr_idx [6];
    logic [31:0] rr_val [3];
    logic [31:0] q_exp;

    rr_tab = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    rr_idx = '{1, 2, 0, 1, 2, 0};

    rst_ni          = 1'b0;
    istek_gecerli_i = 3'b111;
    istek_adres_i   = '0;
    istek_deger_i   = '0;
    rezerve_i       = 1'b0;
    rezerve_adres_i = 5'd0;
    ky1_adres_i     = 5'd0;
    ky2_adres_i     = 5'd0;
    set_req(0, 5'd1, 32'h11);
    #2;
    check("rst_hazir", {29'd0, istek_hazir_o}, 32'd0);
    check("rst_yaz", {31'd0, yaz_o}, 32'd0);
    check("rst_adres", {27'd0, hy_adres_o}, 32'd0);
    check("rst_deger", hy_deger_o, 32'd0);
    check("rst_ileri_deger", ileri_deger_o, 32'd0);
    tick();
    check("rst_yaz_after_edge", {31'd0, yaz_o}, 32'd0);
    istek_gecerli_i = 3'b000;
    rst_ni = 1'b1;

    // Single write from the ALU.
    set_req(0, 5'd5, 32'hDEADBEEF);
    istek_gecerli_i = 3'b001;
    #1;
    check("single_hazir", {29'd0, istek_hazir_o}, 32'b001);
    tick();
    istek_gecerli_i = 3'b000;
    check("single_yaz", {31'd0, yaz_o}, 32'd1);
    check("single_adres", {27'd0, hy_adres_o}, 32'd5);
    check("single_deger", hy_deger_o, 32'hDEADBEEF);
    tick();
    check("single_yaz_drop", {31'd0, yaz_o}, 32'd0);
    check("single_adres_hold", {27'd0, hy_adres_o}, 32'd5);

    // Round robin with all three valid; pointer now at requester 1.
    for (int k = 0; k < 3; k++) begin
      rr_val[k] = 32'hA000_0000 + 32'(k);
      set_req(k, 5'(k + 1), rr_val[k]);
    end
    istek_gecerli_i = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_hazir", {29'd0, istek_hazir_o}, {29'd0, rr_tab[c]});
      exp_q.push_back(rr_val[rr_idx[c]]);
      tick();
      check("rr_yaz", {31'd0, yaz_o}, 32'd1);
      check("rr_adres", {27'd0, hy_adres_o}, 32'(rr_idx[c] + 1));
      q_exp = exp_q.pop_front();
      check("rr_deger", hy_deger_o, q_exp);
      rr_val[rr_idx[c]] = rr_val[rr_idx[c]] + 32'h10;
      set_req(rr_idx[c], 5'(rr_idx[c] + 1), rr_val[rr_idx[c]]);
    end
    istek_gecerli_i = 3'b101;
    #1;
    check("rr_skip_hazir", {29'd0, istek_hazir_o}, 32'b100);
    istek_gecerli_i = 3'b001;
    #1;
    check("rr_wrap_hazir", {29'd0, istek_hazir_o}, 32'b001);
    istek_gecerli_i = 3'b000;
    #1;
    check("rr_none_hazir", {29'd0, istek_hazir_o}, 32'd0);
    tick();
    check("rr_idle_yaz", {31'd0, yaz_o}, 32'd0);

    // x0 write from the load unit: consumed but never written.
    set_req(1, 5'd0, 32'h1234);
    istek_gecerli_i = 3'b010;
    #1;
    check("x0_hazir", {29'd0, istek_hazir_o}, 32'b010);
    tick();
    istek_gecerli_i = 3'b000;
    check("x0_yaz", {31'd0, yaz_o}, 32'd0);
    check("x0_deger", hy_deger_o, 32'h1234);
    check("x0_mesgul", {31'd0, ky1_mesgul_o}, 32'd0);

    // Scoreboard reserve and clear of x7 via mul/div.
    reserve(5'd7);
    ky1_adres_i = 5'd7;
    ky2_adres_i = 5'd8;
    #1;
    check("sb_ky1_busy", {31'd0, ky1_mesgul_o}, 32'd1);
    check("sb_ky2_free", {31'd0, ky2_mesgul_o}, 32'd0);
    set_req(2, 5'd7, 32'h77);
    istek_gecerli_i = 3'b100;
    #1;
    check("sb_hazir", {29'd0, istek_hazir_o}, 32'b100);
    tick();
    istek_gecerli_i = 3'b000;
    check("sb_yaz", {31'd0, yaz_o}, 32'd1);
    check("sb_adres", {27'd0, hy_adres_o}, 32'd7);
`ifdef GERI_YAZMA_ILERI_YONLENDIRME_EN
    check("sb_fw_mesgul", {31'd0, ky1_mesgul_o}, 32'd0);
    check("sb_fw_ileri", {31'd0, ky1_ileri_o}, 32'd1);
    check("sb_fw_deger", ileri_deger_o, 32'h77);
`else
    check("sb_nofw_mesgul", {31'd0, ky1_mesgul_o}, 32'd1);
    check("sb_nofw_ileri", {31'd0, ky1_ileri_o}, 32'd0);
    check("sb_nofw_deger", ileri_deger_o, 32'd0);
`endif
    check("sb_ky2_ileri", {31'd0, ky2_ileri_o}, 32'd0);
    tick();
    check("sb_cleared", {31'd0, ky1_mesgul_o}, 32'd0);
    check("sb_ileri_off", {31'd0, ky1_ileri_o}, 32'd0);

    // Set/clear collision on x9.
    reserve(5'd9);
    set_req(0, 5'd9, 32'h99);
    istek_gecerli_i = 3'b001;
    #1;
    check("col_hazir", {29'd0, istek_hazir_o}, 32'b001);
    tick();
    istek_gecerli_i = 3'b000;
    check("col_yaz", {31'd0, yaz_o}, 32'd1);
    ky1_adres_i = 5'd9;
    reserve(5'd9);
    check("col_set_wins", {31'd0, ky1_mesgul_o}, 32'd1);
    tick();
    check("col_still_busy", {31'd0, ky1_mesgul_o}, 32'd1);

    // Asynchronous reset with a write in flight and x3 busy.
    reserve(5'd3);
    ky1_adres_i = 5'd3;
    set_req(1, 5'd6, 32'h66);
    istek_gecerli_i = 3'b010;
    #1;
    check("ar_hazir", {29'd0, istek_hazir_o}, 32'b010);
    tick();
    istek_gecerli_i = 3'b000;
    check("ar_yaz_before", {31'd0, yaz_o}, 32'd1);
    check("ar_busy_before", {31'd0, ky1_mesgul_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("ar_yaz_drop", {31'd0, yaz_o}, 32'd0);
    check("ar_busy_drop", {31'd0, ky1_mesgul_o}, 32'd0);
    check("ar_adres_clr", {27'd0, hy_adres_o}, 32'd0);
    istek_gecerli_i = 3'b111;
    #1;
    check("ar_hazir_in_rst", {29'd0, istek_hazir_o}, 32'd0);
    rst_ni = 1'b1;
    #1;
    check("ar_first_grant", {29'd0, istek_hazir_o}, 32'b001);
    tick();
    istek_gecerli_i = 3'b000;
    check("ar_first_deger", hy_deger_o, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
